// File: rtl/prewish_mask_responder.sv
// prewish_mask_responder: strobe-loaded 8-bit blink mask, double-buffered, played MSB-first on an LED.
// Optional PREWISH_RESP_IMMEDIATE_EN swaps a captured mask in at once instead of at the pattern boundary.
module prewish_mask_responder #(
  parameter int MASK_CLK_BITS = 9,
  parameter int DATA_W = 8,
  localparam int IW = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              STB_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              o_led,
  output logic [IW-1:0]     o_bit_idx,
  output logic              o_pending
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic stb_q, ack_q, ack_d, led_q, led_d, pend_q, pend_d;
  logic [DATA_W-1:0] act_q, act_d, pmask_q, pmask_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [MASK_CLK_BITS-1:0] pre_q, pre_d;
  logic rise, tick, wrap, swap;
  always_comb begin
    rise = STB_I & ~stb_q;
    tick = (state_q == RUN) && (&pre_q);
    wrap = tick && (idx_q == IW'(DATA_W - 1));
    state_d = state_q;
    act_d = act_q;
    idx_d = idx_q;
    led_d = led_q;
    ack_d = rise;
    pre_d = (state_q == RUN) ? pre_q + 1'b1 : '0;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
      led_d = act_q[IW'(DATA_W - 1) - idx_d];
    end
`ifdef PREWISH_RESP_IMMEDIATE_EN
    swap = rise;
    pend_d = 1'b0;
    pmask_d = pmask_q;
    if (swap) begin
      act_d = DAT_I;
      idx_d = '0;
      pre_d = '0;
      led_d = DAT_I[DATA_W-1];
      state_d = (|DAT_I) ? RUN : IDLE;
    end
`else
    // a swap always consumes the old pending mask; a coincident rise refills it
    swap = pend_q && ((state_q == IDLE) || wrap);
    pend_d = rise | (pend_q & ~swap);
    pmask_d = rise ? DAT_I : pmask_q;
    if (swap) begin
      act_d = pmask_q;
      idx_d = '0;
      pre_d = '0;
      led_d = pmask_q[DATA_W-1];
      state_d = (|pmask_q) ? RUN : IDLE;
    end
`endif
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      stb_q <= 1'b0;
      ack_q <= 1'b0;
      led_q <= 1'b0;
      pend_q <= 1'b0;
      act_q <= '0;
      pmask_q <= '0;
      idx_q <= '0;
      pre_q <= '0;
    end else begin
      state_q <= state_d;
      stb_q <= STB_I;
      ack_q <= ack_d;
      led_q <= led_d;
      pend_q <= pend_d;
      act_q <= act_d;
      pmask_q <= pmask_d;
      idx_q <= idx_d;
      pre_q <= pre_d;
    end
  end
  assign ACK_O = ack_q;
  assign o_led = led_q;
  assign o_bit_idx = idx_q;
  assign o_pending = pend_q;
endmodule

// File: tb/tb_prewish_mask_responder.sv
// tb_prewish_mask_responder: time-based reference model feeds a scoreboard queue; a negedge monitor checks every cycle.
module tb_prewish_mask_responder;
  logic i_clk = 0, i_rst_n = 0, STB_I = 0;
  logic [7:0] DAT_I = '0;
  logic ACK_O, o_led, o_pending;
  logic [2:0] o_bit_idx;
  int total = 0, bad = 0;
  typedef struct packed {logic led; logic [2:0] idx; logic pend; logic ack;} exp_t;
  exp_t sb[$];

  prewish_mask_responder #(.MASK_CLK_BITS(3), .DATA_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .STB_I(STB_I), .DAT_I(DAT_I),
    .ACK_O(ACK_O), .o_led(o_led), .o_bit_idx(o_bit_idx), .o_pending(o_pending));

  always #5 i_clk = ~i_clk;

  // Model: a pattern started at cycle 'start' shows bit (t-start)/8 mod 8, 8 clocks per bit, 64 per pattern.
  int cyc = 0, start = 0;
  logic stb_prev = 0, pend_v = 0, running = 0;
  logic [7:0] pend_m = '0, act = '0;
  always @(posedge i_clk) begin
    logic rise, boundary, swp;
    int k;
    exp_t e;
    cyc++;
    if (!i_rst_n) begin
      stb_prev = 0; pend_v = 0; pend_m = '0; act = '0; running = 0; start = cyc;
    end else begin
      rise = STB_I && !stb_prev;
      stb_prev = STB_I;
      boundary = running && (cyc != start) && ((cyc - start) % 64 == 0);
`ifdef PREWISH_RESP_IMMEDIATE_EN
      if (rise) begin act = DAT_I; start = cyc; running = (DAT_I != 0); end
      pend_v = 0;
`else
      swp = pend_v && (!running || boundary);
      if (swp) begin act = pend_m; start = cyc; running = (pend_m != 0); end
      if (swp) pend_v = 0;
      if (rise) begin pend_v = 1; pend_m = DAT_I; end
`endif
      k = running ? ((cyc - start) / 8) % 8 : 0;
      e.led = running ? act[7-k] : 1'b0;
      e.idx = 3'(k);
      e.pend = pend_v;
      e.ack = rise;
      sb.push_back(e);
    end
  end

  always @(negedge i_clk) begin
    exp_t e, g;
    g = {o_led, o_bit_idx, o_pending, ACK_O};
    if (!i_rst_n) begin
      sb.delete();
      e = '0;
    end else if (sb.size() > 0) e = sb.pop_front();
    else e = g;
    if (!i_rst_n || e !== g || sb.size() == 0) begin
      total++;
      if (g !== e) begin
        bad++;
        if (bad <= 30) $display("FAIL resp cyc=%0d got led/idx/pend/ack=%b want %b", cyc, g, e);
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic load(input logic [7:0] m, input int hold);
    DAT_I = m; STB_I = 1;
    tick_n(hold);
    STB_I = 0; DAT_I = 8'($urandom);
    tick_n(1);
  endtask

  initial begin
    tick_n(3);
    i_rst_n = 1;
    tick_n(20);
    load(8'hA8, 1);
    tick_n(140);
    load(8'hCA, 30);
    tick_n(70);
    load(8'hA8, 1);
    tick_n(25);
    load(8'hF0, 1);
    tick_n(80);
    load(8'h81, 2);
    tick_n(3);
    load(8'h3C, 1);
    tick_n(140);
    load(8'h00, 1);
    tick_n(90);
    load(8'hA8, 1);
    tick_n(20);
    #1 i_rst_n = 0;
    #1;
    total++;
    if ({o_led, o_bit_idx, o_pending, ACK_O} !== 6'b0) begin
      bad++;
      $display("FAIL async_reset got %b want 000000", {o_led, o_bit_idx, o_pending, ACK_O});
    end
    tick_n(3);
    i_rst_n = 1;
    tick_n(5);
    for (int i = 0; i < 40; i++) begin
      load(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), $urandom_range(1, 4));
      tick_n($urandom_range(1, 90));
    end
    tick_n(70);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
